// File: rtl/cbus_wb_cache_pkg.sv
// Shared types for the write-back data cache: cbus request/response, cache line, FSM encoding.
package cbus_wb_cache_pkg;

   localparam logic [2:0] MSIZE1 = 3'd0;
   localparam logic [2:0] MSIZE2 = 3'd1;
   localparam logic [2:0] MSIZE4 = 3'd2;
   localparam logic [2:0] MSIZE8 = 3'd3;
   localparam logic [3:0] MLEN1  = 4'd0;
   localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
   localparam logic [1:0] AXI_BURST_INCR  = 2'b01;

   typedef struct packed {
      logic        valid;
      logic        is_write;
      logic [2:0]  size;
      logic [63:0] addr;
      logic [7:0]  strobe;
      logic [63:0] data;
      logic [3:0]  len;
      logic [1:0]  burst;
   } cbus_req_t;

   typedef struct packed {
      logic        ready;
      logic        last;
      logic [63:0] data;
   } cbus_resp_t;

   // Tag sized for the smallest index; larger configurations leave the top bits zero.
   typedef struct packed {
      logic        valid;
      logic        dirty;
      logic [60:0] tag;
      logic [63:0] data;
   } cache_line_t;

   typedef logic [2:0] cache_state_t;
   localparam cache_state_t S_IDLE    = 3'd0;
   localparam cache_state_t S_RESP    = 3'd1;
   localparam cache_state_t S_BYPASS  = 3'd2;
   localparam cache_state_t S_EVICT   = 3'd3;
   localparam cache_state_t S_FILL    = 3'd4;
   localparam cache_state_t S_FL_SCAN = 3'd5;
   localparam cache_state_t S_FL_WB   = 3'd6;
   localparam cache_state_t S_FL_DONE = 3'd7;

   function automatic logic [63:0] strobe_to_mask(input logic [7:0] strobe);
      logic [63:0] m;
      m = '0;
      for (int i = 0; i < 8; i++) m[8*i +: 8] = {8{strobe[i]}};
      return m;
   endfunction

   function automatic cbus_req_t line_req(input logic we, input logic [63:0] a, input logic [63:0] d);
      cbus_req_t r;
      r          = '0;
      r.valid    = 1'b1;
      r.is_write = we;
      r.size     = MSIZE8;
      r.addr     = a;
      r.strobe   = 8'hFF;
      r.data     = d;
      r.len      = MLEN1;
      r.burst    = AXI_BURST_FIXED;
      return r;
   endfunction

endpackage

// File: rtl/cbus_wb_cache_lru.sv
// True-LRU age logic for one set: picks a victim and computes ages after touching a way.
module cbus_cache_lru #(
   parameter int NUM_WAYS = 2,
   parameter int AGE_W    = 1
) (
   input  logic [NUM_WAYS-1:0][AGE_W-1:0] ages_i,
   input  logic [NUM_WAYS-1:0]            valid_i,
   input  logic [AGE_W-1:0]               touch_way_i,
   output logic [AGE_W-1:0]               victim_o,
   output logic [NUM_WAYS-1:0][AGE_W-1:0] ages_o
);

   logic             found;
   logic [AGE_W-1:0] old_age;

   // Ages are a permutation, so the oldest way is the one holding NUM_WAYS-1.
   always_comb begin
      victim_o = '0;
      found    = 1'b0;
      for (int w = 0; w < NUM_WAYS; w++) begin
         if (!valid_i[w] && !found) begin
            victim_o = AGE_W'(w);
            found    = 1'b1;
         end
      end
      if (!found) begin
         for (int w = 0; w < NUM_WAYS; w++)
            if (ages_i[w] == AGE_W'(NUM_WAYS-1)) victim_o = AGE_W'(w);
      end
   end

   always_comb begin
      old_age = ages_i[touch_way_i];
      ages_o  = ages_i;
      for (int w = 0; w < NUM_WAYS; w++) begin
         if (AGE_W'(w) == touch_way_i) ages_o[w] = '0;
         else if (ages_i[w] < old_age) ages_o[w] = ages_i[w] + AGE_W'(1);
      end
   end

endmodule

// File: rtl/cbus_wb_cache.sv
// Write-back, write-allocate set-associative data cache between the MMU cbus and the memory cbus.
module cbus_wb_cache
   import cbus_wb_cache_pkg::*;
#(
   parameter int NUM_SETS     = 32,
   parameter int NUM_WAYS     = 2,
   parameter int UNCACHED_BIT = 31
) (
   input  logic       clk,
   input  logic       reset,
   input  cbus_req_t  request_from_mmu,
   output cbus_resp_t response_to_mmu,
   output cbus_req_t  request_to_mem,
   input  cbus_resp_t response_from_mem,
   input  logic       flush_req,
   output logic       flush_done
);

   localparam int IDX_W = $clog2(NUM_SETS);
   localparam int AGE_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
   localparam int TAG_W = 61 - IDX_W;

   cache_state_t state_q, state_d;
   cache_line_t  lines_q [NUM_SETS][NUM_WAYS];
   cache_line_t  lines_d [NUM_SETS][NUM_WAYS];
   logic [NUM_WAYS-1:0][AGE_W-1:0] age_q [NUM_SETS];
   logic [NUM_WAYS-1:0][AGE_W-1:0] age_d [NUM_SETS];
   cbus_resp_t   resp_q, resp_d;
   cbus_req_t    mreq_q, mreq_d;
   logic [AGE_W-1:0] victim_q, victim_d, fl_way_q, fl_way_d, fl_way_nxt;
   logic [IDX_W-1:0] fl_set_q, fl_set_d, fl_set_nxt;

   logic [IDX_W-1:0] idx;
   logic [TAG_W-1:0] tag;
   logic             hit, fl_last;
   logic [AGE_W-1:0] hit_way, touch_way, lru_victim;
   logic [NUM_WAYS-1:0] way_valid;
   logic [NUM_WAYS-1:0][AGE_W-1:0] lru_ages;
   logic [63:0]      mask, hit_merged, fill_data;
   cache_line_t      hit_line, vic_line, fl_line, fill_line;

   assign idx       = request_from_mmu.addr[3 +: IDX_W];
   assign tag       = request_from_mmu.addr[63 -: TAG_W];
   assign mask      = strobe_to_mask(request_from_mmu.strobe);
   assign hit_line  = lines_q[idx][hit_way];
   assign vic_line  = lines_q[idx][lru_victim];
   assign fl_line   = lines_q[fl_set_q][fl_way_q];
   assign touch_way = (state_q == S_FILL) ? victim_q : hit_way;
   assign hit_merged = (hit_line.data & ~mask) | (request_from_mmu.data & mask);
   assign fill_data  = request_from_mmu.is_write ?
                       ((response_from_mem.data & ~mask) | (request_from_mmu.data & mask)) :
                       response_from_mem.data;
   assign fl_last    = (fl_set_q == IDX_W'(NUM_SETS-1)) && (fl_way_q == AGE_W'(NUM_WAYS-1));
   assign fl_way_nxt = (fl_way_q == AGE_W'(NUM_WAYS-1)) ? '0 : fl_way_q + AGE_W'(1);
   assign fl_set_nxt = (fl_way_q == AGE_W'(NUM_WAYS-1)) ? fl_set_q + IDX_W'(1) : fl_set_q;

   always_comb begin
      hit       = 1'b0;
      hit_way   = '0;
      way_valid = '0;
      for (int w = 0; w < NUM_WAYS; w++) begin
         way_valid[w] = lines_q[idx][w].valid;
         if (lines_q[idx][w].valid && lines_q[idx][w].tag[TAG_W-1:0] == tag) begin
            hit     = 1'b1;
            hit_way = AGE_W'(w);
         end
      end
   end

   always_comb begin
      fill_line                 = '0;
      fill_line.valid           = 1'b1;
      fill_line.dirty           = request_from_mmu.is_write;
      fill_line.tag[TAG_W-1:0]  = tag;
      fill_line.data            = fill_data;
   end

   cbus_cache_lru #(.NUM_WAYS(NUM_WAYS), .AGE_W(AGE_W)) u_lru (
      .ages_i      (age_q[idx]),
      .valid_i     (way_valid),
      .touch_way_i (touch_way),
      .victim_o    (lru_victim),
      .ages_o      (lru_ages)
   );

   always_comb begin
      state_d  = state_q;
      lines_d  = lines_q;
      age_d    = age_q;
      resp_d   = resp_q;
      mreq_d   = mreq_q;
      victim_d = victim_q;
      fl_set_d = fl_set_q;
      fl_way_d = fl_way_q;
      case (state_q)
         S_IDLE: begin
            if (flush_req) begin
               fl_set_d = '0;
               fl_way_d = '0;
               state_d  = S_FL_SCAN;
            end else if (request_from_mmu.valid) begin
               if (!request_from_mmu.addr[UNCACHED_BIT]) begin
                  mreq_d  = request_from_mmu;
                  state_d = S_BYPASS;
               end else if (hit) begin
                  resp_d = '{ready: 1'b1, last: 1'b1, data: hit_line.data};
                  if (request_from_mmu.is_write) begin
                     lines_d[idx][hit_way].data  = hit_merged;
                     lines_d[idx][hit_way].dirty = 1'b1;
                  end
                  age_d[idx] = lru_ages;
                  state_d    = S_RESP;
               end else begin
                  victim_d = lru_victim;
                  if (vic_line.valid && vic_line.dirty) begin
                     mreq_d  = line_req(1'b1, {vic_line.tag[TAG_W-1:0], idx, 3'b000}, vic_line.data);
                     state_d = S_EVICT;
                  end else begin
                     mreq_d  = line_req(1'b0, {tag, idx, 3'b000}, '0);
                     state_d = S_FILL;
                  end
               end
            end
         end
         S_EVICT: begin
            if (response_from_mem.ready) begin
               mreq_d  = '0;
               state_d = S_FILL;
            end
         end
         S_FILL: begin
            // After an eviction the read goes out one cycle after the write completes.
            if (!mreq_q.valid) begin
               mreq_d = line_req(1'b0, {tag, idx, 3'b000}, '0);
            end else if (response_from_mem.ready) begin
               mreq_d                 = '0;
               lines_d[idx][victim_q] = fill_line;
               age_d[idx]             = lru_ages;
               resp_d                 = '{ready: 1'b1, last: 1'b1, data: fill_data};
               state_d                = S_RESP;
            end
         end
         S_BYPASS: begin
            if (response_from_mem.ready) begin
               resp_d  = response_from_mem;
               mreq_d  = '0;
               state_d = S_RESP;
            end
         end
         S_RESP: begin
            resp_d  = '0;
            state_d = S_IDLE;
         end
         S_FL_SCAN: begin
            lines_d[fl_set_q][fl_way_q].valid = 1'b0;
            lines_d[fl_set_q][fl_way_q].dirty = 1'b0;
            if (fl_line.valid && fl_line.dirty) begin
               mreq_d  = line_req(1'b1, {fl_line.tag[TAG_W-1:0], fl_set_q, 3'b000}, fl_line.data);
               state_d = S_FL_WB;
            end else if (fl_last) begin
               state_d = S_FL_DONE;
            end else begin
               fl_set_d = fl_set_nxt;
               fl_way_d = fl_way_nxt;
            end
         end
         S_FL_WB: begin
            if (response_from_mem.ready) begin
               mreq_d = '0;
               if (fl_last) begin
                  state_d = S_FL_DONE;
               end else begin
                  fl_set_d = fl_set_nxt;
                  fl_way_d = fl_way_nxt;
                  state_d  = S_FL_SCAN;
               end
            end
         end
         S_FL_DONE: state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         resp_q   <= '0;
         mreq_q   <= '0;
         victim_q <= '0;
         fl_set_q <= '0;
         fl_way_q <= '0;
         for (int s = 0; s < NUM_SETS; s++)
            for (int w = 0; w < NUM_WAYS; w++) begin
               lines_q[s][w] <= '0;
               age_q[s][w]   <= AGE_W'(w);
            end
      end else begin
         state_q  <= state_d;
         resp_q   <= resp_d;
         mreq_q   <= mreq_d;
         victim_q <= victim_d;
         fl_set_q <= fl_set_d;
         fl_way_q <= fl_way_d;
         lines_q  <= lines_d;
         age_q    <= age_d;
      end
   end

   assign response_to_mmu = resp_q;
   assign request_to_mem  = mreq_q;
   assign flush_done      = (state_q == S_FL_DONE);

endmodule

// File: tb/tb_cbus_wb_cache.sv
// Directed bench for cbus_wb_cache with a fixed-latency memory responder that logs accepted requests.
module tb_cbus_wb_cache;
   import cbus_wb_cache_pkg::*;

   localparam int MEM_LAT = 2;

   logic       clk = 1'b0;
   logic       reset;
   cbus_req_t  mmu_req, mem_req, exp_req;
   cbus_resp_t mmu_resp, mem_resp;
   logic       flush_req, flush_done;
   logic       mem_ready = 1'b0;
   logic [63:0] mem_rd_data = '0;
   int         mem_cnt = 0;
   cbus_req_t  log_req [0:63];
   int         log_cnt = 0;
   int         checks = 0, errors = 0;

   always #5 clk = ~clk;

   cbus_wb_cache dut (
      .clk               (clk),
      .reset             (reset),
      .request_from_mmu  (mmu_req),
      .response_to_mmu   (mmu_resp),
      .request_to_mem    (mem_req),
      .response_from_mem (mem_resp),
      .flush_req         (flush_req),
      .flush_done        (flush_done)
   );

   assign mem_resp = {mem_ready, mem_ready, mem_ready ? mem_rd_data : 64'h0};

   always @(negedge clk) begin
      if (reset) begin
         mem_ready = 1'b0;
         mem_cnt   = 0;
      end else if (mem_ready) begin
         mem_ready = 1'b0;
      end else if (mem_req.valid) begin
         if (mem_cnt == MEM_LAT-1) begin
            mem_ready = 1'b1;
            mem_cnt   = 0;
            if (log_cnt < 64) log_req[log_cnt] = mem_req;
            log_cnt++;
         end else begin
            mem_cnt++;
         end
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic access(input logic we, input logic [63:0] addr, input logic [63:0] data,
                         input logic [7:0] strb, output logic [63:0] rd, output int cyc);
      @(negedge clk);
      mmu_req          = '0;
      mmu_req.valid    = 1'b1;
      mmu_req.is_write = we;
      mmu_req.size     = MSIZE8;
      mmu_req.addr     = addr;
      mmu_req.strobe   = strb;
      mmu_req.data     = data;
      mmu_req.len      = MLEN1;
      mmu_req.burst    = AXI_BURST_FIXED;
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!mmu_resp.ready && cyc < 100);
      chk("resp_timeout", 64'(mmu_resp.ready), 64'd1);
      rd      = mmu_resp.data;
      mmu_req = '0;
   endtask

   task automatic do_flush(output int pulses);
      @(negedge clk);
      flush_req = 1'b1;
      @(negedge clk);
      flush_req = 1'b0;
      pulses = 0;
      for (int i = 0; i < 400; i++) begin
         if (flush_done) pulses++;
         @(negedge clk);
      end
   endtask

   logic [63:0] rd;
   int          cyc, base, pulses;

   initial begin
      reset = 1'b1; mmu_req = '0; flush_req = 1'b0; exp_req = '0;
      repeat (3) @(negedge clk);
      chk("rst_resp", 64'(|mmu_resp), 64'd0);
      chk("rst_memreq", 64'(|mem_req), 64'd0);
      chk("rst_flush_done", 64'(flush_done), 64'd0);
      reset = 1'b0;

      // read miss then hit
      base = log_cnt; mem_rd_data = 64'h1122334455667788;
      access(1'b0, 64'h8000_0010, 64'h0, 8'hFF, rd, cyc);
      chk("rdmiss_data", rd, 64'h1122334455667788);
      chk("rdmiss_lat", 64'(cyc), 64'd3);
      chk("rdmiss_nreq", 64'(log_cnt - base), 64'd1);
      chk("rdmiss_addr", log_req[base].addr, 64'h8000_0010);
      chk("rdmiss_we", 64'(log_req[base].is_write), 64'd0);
      chk("rdmiss_strb", 64'(log_req[base].strobe), 64'hFF);
      access(1'b0, 64'h8000_0010, 64'h0, 8'hFF, rd, cyc);
      chk("rdhit_data", rd, 64'h1122334455667788);
      chk("rdhit_lat", 64'(cyc), 64'd1);
      chk("rdhit_nreq", 64'(log_cnt - base), 64'd1);

      // write hit, top byte only
      access(1'b1, 64'h8000_0010, 64'hAB00_0000_0000_0000, 8'h80, rd, cyc);
      chk("wrhit_old", rd, 64'h1122334455667788);
      chk("wrhit_lat", 64'(cyc), 64'd1);
      access(1'b0, 64'h8000_0010, 64'h0, 8'hFF, rd, cyc);
      chk("wrhit_merged", rd, 64'hAB22334455667788);
      chk("wrhit_nreq", 64'(log_cnt - base), 64'd1);

      // set-2 conflict: A, B(write), A, C -> B evicted
      base = log_cnt; mem_rd_data = 64'hDEAD_BEEF_0000_0000;
      access(1'b1, 64'h8000_0110, 64'h5555_6666_7777_8888, 8'hFF, rd, cyc);
      chk("wrmiss_data", rd, 64'h5555_6666_7777_8888);
      chk("wrmiss_lat", 64'(cyc), 64'd3);
      chk("wrmiss_addr", log_req[base].addr, 64'h8000_0110);
      access(1'b0, 64'h8000_0010, 64'h0, 8'hFF, rd, cyc);
      chk("touchA_lat", 64'(cyc), 64'd1);
      base = log_cnt; mem_rd_data = 64'h0C0C_0C0C_0C0C_0C0C;
      access(1'b0, 64'h8000_0210, 64'h0, 8'hFF, rd, cyc);
      chk("dirty_data", rd, 64'h0C0C_0C0C_0C0C_0C0C);
      chk("dirty_lat", 64'(cyc), 64'd6);
      chk("dirty_nreq", 64'(log_cnt - base), 64'd2);
      chk("evict_we", 64'(log_req[base].is_write), 64'd1);
      chk("evict_addr", log_req[base].addr, 64'h8000_0110);
      chk("evict_data", log_req[base].data, 64'h5555_6666_7777_8888);
      chk("fillC_we", 64'(log_req[base+1].is_write), 64'd0);
      chk("fillC_addr", log_req[base+1].addr, 64'h8000_0210);
      access(1'b0, 64'h8000_0010, 64'h0, 8'hFF, rd, cyc);
      chk("A_kept_lat", 64'(cyc), 64'd1);

      // uncached write is forwarded verbatim
      base = log_cnt; mem_rd_data = 64'hCAFE_F00D_1234_5678;
      exp_req = '0; exp_req.valid = 1'b1; exp_req.is_write = 1'b1; exp_req.size = MSIZE8;
      exp_req.addr = 64'h1000_0000; exp_req.strobe = 8'h0F; exp_req.data = 64'h0123_4567_89AB_CDEF;
      exp_req.len = MLEN1; exp_req.burst = AXI_BURST_FIXED;
      access(1'b1, 64'h1000_0000, 64'h0123_4567_89AB_CDEF, 8'h0F, rd, cyc);
      chk("byp_lat", 64'(cyc), 64'd3);
      chk("byp_data", rd, 64'hCAFE_F00D_1234_5678);
      chk("byp_nreq", 64'(log_cnt - base), 64'd1);
      checks++;
      assert (log_req[base] === exp_req) else begin
         errors++;
         $error("FAIL byp_verbatim: observed %h expected %h", log_req[base], exp_req);
      end
      access(1'b0, 64'h8000_0010, 64'h0, 8'hFF, rd, cyc);
      chk("byp_cache_lat", 64'(cyc), 64'd1);
      chk("byp_cache_data", rd, 64'hAB22334455667788);

      // flush with only A dirty
      base = log_cnt;
      do_flush(pulses);
      chk("fl1_pulses", 64'(pulses), 64'd1);
      chk("fl1_nreq", 64'(log_cnt - base), 64'd1);
      chk("fl1_addr", log_req[base].addr, 64'h8000_0010);
      chk("fl1_data", log_req[base].data, 64'hAB22334455667788);
      chk("fl1_we", 64'(log_req[base].is_write), 64'd1);
      mem_rd_data = 64'h7777_7777_7777_7777;
      access(1'b0, 64'h8000_0010, 64'h0, 8'hFF, rd, cyc);
      chk("fl1_miss_lat", 64'(cyc), 64'd3);
      chk("fl1_miss_data", rd, 64'h7777_7777_7777_7777);

      // flush with dirty lines in sets 0, 5, 31
      access(1'b1, 64'h8000_0000, 64'h1010_1010_1010_1010, 8'hFF, rd, cyc);
      access(1'b1, 64'h8000_0028, 64'h5050_5050_5050_5050, 8'hFF, rd, cyc);
      access(1'b1, 64'h8000_00F8, 64'h3131_3131_3131_3131, 8'hFF, rd, cyc);
      base = log_cnt;
      do_flush(pulses);
      chk("fl2_pulses", 64'(pulses), 64'd1);
      chk("fl2_nreq", 64'(log_cnt - base), 64'd3);
      chk("fl2_addr0", log_req[base].addr, 64'h8000_0000);
      chk("fl2_addr1", log_req[base+1].addr, 64'h8000_0028);
      chk("fl2_addr2", log_req[base+2].addr, 64'h8000_00F8);
      chk("fl2_data0", log_req[base].data, 64'h1010_1010_1010_1010);
      chk("fl2_data2", log_req[base+2].data, 64'h3131_3131_3131_3131);
      access(1'b0, 64'h8000_0000, 64'h0, 8'hFF, rd, cyc);
      chk("fl2_miss0", 64'(cyc), 64'd3);
      access(1'b0, 64'h8000_0028, 64'h0, 8'hFF, rd, cyc);
      chk("fl2_miss5", 64'(cyc), 64'd3);
      access(1'b0, 64'h8000_00F8, 64'h0, 8'hFF, rd, cyc);
      chk("fl2_miss31", 64'(cyc), 64'd3);

      // reset while evicting D from set 8
      access(1'b1, 64'h8000_0040, 64'hD0D0_D0D0_D0D0_D0D0, 8'hFF, rd, cyc);
      access(1'b1, 64'h8000_0140, 64'hE0E0_E0E0_E0E0_E0E0, 8'hFF, rd, cyc);
      base = log_cnt;
      @(negedge clk);
      mmu_req = '0; mmu_req.valid = 1'b1; mmu_req.size = MSIZE8;
      mmu_req.addr = 64'h8000_0240; mmu_req.strobe = 8'hFF;
      @(negedge clk);
      chk("ev_valid", 64'(mem_req.valid), 64'd1);
      chk("ev_we", 64'(mem_req.is_write), 64'd1);
      chk("ev_addr", mem_req.addr, 64'h8000_0040);
      reset = 1'b1;
      @(negedge clk);
      chk("mid_rst_resp", 64'(|mmu_resp), 64'd0);
      chk("mid_rst_memreq", 64'(|mem_req), 64'd0);
      chk("mid_rst_flush", 64'(flush_done), 64'd0);
      mmu_req = '0;
      @(negedge clk);
      reset = 1'b0;
      chk("mid_rst_nreq", 64'(log_cnt - base), 64'd0);
      mem_rd_data = 64'h9999_0000_9999_0000;
      access(1'b0, 64'h8000_0040, 64'h0, 8'hFF, rd, cyc);
      chk("post_rst_lat", 64'(cyc), 64'd3);
      chk("post_rst_data", rd, 64'h9999_0000_9999_0000);
      chk("post_rst_nreq", 64'(log_cnt - base), 64'd1);
      chk("post_rst_we", 64'(log_req[base].is_write), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
